ddr3_write_issuer: RTL and testbench
====================================

# ddr3_write_issuer

Write-side request engine for the DDR3 memory path: accepts write requests (28-bit address, 128-bit data, 16-bit byte mask) from the MCU over a valid/ready handshake and buffers them in a small FIFO. It drives the MIG 7-series application command and write-data channels (app_en/app_cmd/app_addr and app_wdf_*). It is the write counterpart of the read-data capture path fed by app_rd_data. It runs entirely in the MIG UI clock domain.

## Interface
- ADDR_WIDTH, 28, MIG app_addr width (rank/bank/row/column)
- DATA_WIDTH, 128, one app_wdf beat (BL8 x 16-bit DQ)
- MASK_WIDTH, 16, DATA_WIDTH/8 byte-mask bits
- FIFO_DEPTH, 4, request buffer entries; power of 2, at least 2

- clk_166M66  in  1  MIG ui_clk; all logic on rising edge
- mcu_sys_rst  in  1  asynchronous, active-high reset
- i_init_calib_complete  in  1  MIG calibration done
- i_wr_valid  in  1  write request present
- o_wr_ready  out  1  request accepted when valid&ready
- i_wr_addr  in  ADDR_WIDTH  target address
- i_wr_data  in  DATA_WIDTH  write data
- i_wr_mask  in  MASK_WIDTH  1 = byte NOT written (MIG polarity)
- o_app_addr  out  ADDR_WIDTH  to app_addr
- o_app_cmd  out  3  to app_cmd; constant 3'b000 (write)
- o_app_en  out  1  to app_en
- i_app_rdy  in  1  from app_rdy
- o_app_wdf_data  out  DATA_WIDTH  to app_wdf_data
- o_app_wdf_mask  out  MASK_WIDTH  to app_wdf_mask
- o_app_wdf_wren  out  1  to app_wdf_wren
- o_app_wdf_end  out  1  to app_wdf_end
- i_app_wdf_rdy  in  1  from app_wdf_rdy
- o_busy  out  1  FIFO non-empty
- o_wr_done  out  1  one-cycle pulse per retired request

## Operation
- FIFO: FIFO_DEPTH entries of {addr, data, mask}. Registered wr_ptr, rd_ptr and count, where count is $clog2(FIFO_DEPTH)+1 bits wide. Pointers wrap modulo FIFO_DEPTH.
- Push when i_wr_valid & o_wr_ready. o_wr_ready = (count != FIFO_DEPTH).
- When full, no push occurs even if a pop happens in the same cycle.
- Head entry carries two registered flags, cmd_done and data_done. Per-head state:
  - EMPTY (count==0): go to BOTH_PEND on push.
  - BOTH_PEND: both halves issuable.
  - CMD_PEND: data_done=1; only the command remains.
  - DATA_PEND: cmd_done=1; only the data remains.
- Issue rules:
  - o_app_en = head valid & i_init_calib_complete & ~cmd_done.
  - o_app_wdf_wren = head valid & i_init_calib_complete & ~data_done.
  - o_app_wdf_end = o_app_wdf_wren, because one beat completes a burst.
- Command handshake: o_app_en & i_app_rdy. Data handshake: o_app_wdf_wren & i_app_wdf_rdy. The two channels complete independently, in any order or in the same cycle.
- Retire (pop) occurs in the cycle the last outstanding half handshakes. On retire: both flags clear, rd_ptr advances, and o_wr_done pulses in the next cycle (registered).
- A retire and a push in the same cycle leave count unchanged.
- o_app_addr, o_app_wdf_data and o_app_wdf_mask reflect the head entry. They are 0 when the FIFO is empty and stay stable while the head is pending.
- When i_init_calib_complete deasserts mid-request, app_en and wdf_wren drop immediately and the flags are held. Issue resumes when it reasserts. Pushes continue while space remains.
- o_busy = (count != 0).

## Timing
- Reset values:
  - o_app_en, o_app_wdf_wren, o_app_wdf_end, o_wr_done, o_busy = 0.
  - o_app_addr, o_app_wdf_data, o_app_wdf_mask = 0.
  - o_app_cmd = 3'b000.
  - o_wr_ready = 1.
  - Pointers, count and flags = 0.
- Reset mid-operation flushes all entries and clears the flags. Half-issued requests are dropped.
- Latency, empty FIFO with calibration done: push in cycle N; o_app_en and o_app_wdf_wren assert in N+1.
- With both ready signals high in N+1, the request retires at the end of N+1, o_wr_done pulses in N+2, and the next entry issues in N+2.
- Sustained throughput is 1 request per cycle when both ready signals are held high.
- No combinational path from i_wr_valid to any app_* output.
- The i_app_rdy and i_app_wdf_rdy paths to o_wr_ready go only through registered count.

## Test plan
- Single write, calibration high, both ready signals high: push addr=0x0000100, data=0xA5…A5, mask=0.
  - Cycle+1: app_en=1, wdf_wren=1, wdf_end=1, app_cmd=0.
  - Cycle+2: o_wr_done=1, o_busy=0.
- Split handshake: i_app_rdy=0 for 3 cycles while i_app_wdf_rdy=1.
  - Data is accepted in the first cycle and wdf_wren drops.
  - app_en stays high with a stable address until rdy rises; exactly one o_wr_done follows.
- Reverse order: command accepted first, and i_app_wdf_rdy is delayed 5 cycles.
  - app_en drops after its handshake, wren is held, and the entry retires on the data handshake.
- Fill: 4 pushes with both ready signals low.
  - o_wr_ready=0 after the 4th push.
  - Releasing the ready signals retires 4 entries in order: addresses 0x10, 0x20, 0x30, 0x40 on consecutive cycles.
- Calibration gating: push 2 requests with i_init_calib_complete=0.
  - No app_en or wren is asserted and o_busy=1.
  - When calibration asserts, both requests issue in order.
- Asynchronous reset asserted mid-request while in CMD_PEND: all outputs return to reset values immediately, and the FIFO is empty after release.

Source files
------------

// File: rtl/ddr3_write_issuer.sv
// Write-side request engine for the MIG 7-series UI: buffers {addr, data, mask}
// requests in a small FIFO and issues the command and write-data halves of the head entry.
module ddr3_write_issuer #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_166M66,
    input  logic                  mcu_sys_rst,
    input  logic                  i_init_calib_complete,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [MASK_WIDTH-1:0] i_wr_mask,
    output logic [ADDR_WIDTH-1:0] o_app_addr,
    output logic [2:0]            o_app_cmd,
    output logic                  o_app_en,
    input  logic                  i_app_rdy,
    output logic [DATA_WIDTH-1:0] o_app_wdf_data,
    output logic [MASK_WIDTH-1:0] o_app_wdf_mask,
    output logic                  o_app_wdf_wren,
    output logic                  o_app_wdf_end,
    input  logic                  i_app_wdf_rdy,
    output logic                  o_busy,
    output logic                  o_wr_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0] CMD_WRITE = 3'b000;

    // Progress of the head entry; CMD_PEND means the data beat is already accepted.
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_BOTH_PEND,
        ST_CMD_PEND,
        ST_DATA_PEND
    } head_state_t;

    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [MASK_WIDTH-1:0] fifo_mask [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    head_state_t      state;
    head_state_t      state_next;

    logic head_valid;
    logic issue_ok;
    logic cmd_done;
    logic data_done;
    logic cmd_hs;
    logic data_hs;
    logic push;
    logic pop;

    assign head_valid = (count != '0);
    assign issue_ok   = head_valid & i_init_calib_complete;
    assign cmd_done   = (state == ST_DATA_PEND);
    assign data_done  = (state == ST_CMD_PEND);

    assign o_wr_ready = (count != FULL_CNT);
    assign o_busy     = head_valid;
    assign o_app_cmd  = CMD_WRITE;

    assign push    = i_wr_valid & o_wr_ready;
    assign cmd_hs  = o_app_en & i_app_rdy;
    assign data_hs = o_app_wdf_wren & i_app_wdf_rdy;
    assign pop     = head_valid & (cmd_done | cmd_hs) & (data_done | data_hs);

    // NOTE: storage carries no reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk_166M66) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_wr_addr;
            fifo_data[wr_ptr] <= i_wr_data;
            fifo_mask[wr_ptr] <= i_wr_mask;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_166M66 or posedge mcu_sys_rst) begin
        if (mcu_sys_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_wr_done <= 1'b0;
        end else begin
            o_wr_done <= pop;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_166M66 or posedge mcu_sys_rst) begin
        if (mcu_sys_rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (push) state_next = ST_BOTH_PEND;
            end
            default: begin
                if (pop) begin
                    // A following entry starts fresh with both halves pending.
                    state_next = ((count > CNT_W'(1)) || push) ? ST_BOTH_PEND : ST_EMPTY;
                end else if (state == ST_BOTH_PEND) begin
                    if (cmd_hs)       state_next = ST_DATA_PEND;
                    else if (data_hs) state_next = ST_CMD_PEND;
                end
            end
        endcase
    end

    always_comb begin
        o_app_en       = issue_ok & ~cmd_done;
        o_app_wdf_wren = issue_ok & ~data_done;
        o_app_wdf_end  = o_app_wdf_wren;
        o_app_addr     = '0;
        o_app_wdf_data = '0;
        o_app_wdf_mask = '0;
        if (head_valid) begin
            o_app_addr     = fifo_addr[rd_ptr];
            o_app_wdf_data = fifo_data[rd_ptr];
            o_app_wdf_mask = fifo_mask[rd_ptr];
        end
    end

endmodule

// File: tb/tb_ddr3_write_issuer.sv
// Self-checking bench for ddr3_write_issuer: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_ddr3_write_issuer;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          calib;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [MW-1:0] wr_mask;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_rdy;
    logic [DW-1:0] wdf_data;
    logic [MW-1:0] wdf_mask;
    logic          wdf_wren;
    logic          wdf_end;
    logic          wdf_rdy;
    logic          busy;
    logic          wr_done;

    int checks = 0;
    int errors = 0;

    ddr3_write_issuer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_166M66           (clk),
        .mcu_sys_rst          (rst),
        .i_init_calib_complete(calib),
        .i_wr_valid           (wr_valid),
        .o_wr_ready           (wr_ready),
        .i_wr_addr            (wr_addr),
        .i_wr_data            (wr_data),
        .i_wr_mask            (wr_mask),
        .o_app_addr           (app_addr),
        .o_app_cmd            (app_cmd),
        .o_app_en             (app_en),
        .i_app_rdy            (app_rdy),
        .o_app_wdf_data       (wdf_data),
        .o_app_wdf_mask       (wdf_mask),
        .o_app_wdf_wren       (wdf_wren),
        .o_app_wdf_end        (wdf_end),
        .i_app_wdf_rdy        (wdf_rdy),
        .o_busy               (busy),
        .o_wr_done            (wr_done)
    );

    initial clk = 1'b0;
    always #3 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Payload derived from the address so the head's data and mask can be predicted.
    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {4{a ^ 28'h5A5A5A5, 4'hA}};
    endfunction

    function automatic logic [MW-1:0] mask_of(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hF0F0;
    endfunction

    typedef struct {
        logic          valid;
        logic [AW-1:0] addr;
        logic          calib;
        logic          rdy;
        logic          wdf_rdy;
        logic          e_ready;
        logic          e_en;
        logic          e_wren;
        logic          e_done;
        logic          e_busy;
        logic [AW-1:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [AW-1:0] a, input logic c,
                                input logic r, input logic w, input logic e_ready,
                                input logic e_en, input logic e_wren, input logic e_done,
                                input logic e_busy, input logic [AW-1:0] e_addr);
        vec_t t;
        t.valid = v; t.addr = a; t.calib = c; t.rdy = r; t.wdf_rdy = w;
        t.e_ready = e_ready; t.e_en = e_en; t.e_wren = e_wren;
        t.e_done = e_done; t.e_busy = e_busy; t.e_addr = e_addr;
        return t;
    endfunction

    // Drive one cycle's inputs at the falling edge and check outputs just after.
    task automatic apply(input string tag, input vec_t t);
        @(negedge clk);
        wr_valid = t.valid;
        wr_addr  = t.addr;
        wr_data  = data_of(t.addr);
        wr_mask  = mask_of(t.addr);
        calib    = t.calib;
        app_rdy  = t.rdy;
        wdf_rdy  = t.wdf_rdy;
        #1;
        check({tag, " ready"}, wr_ready, t.e_ready);
        check({tag, " app_en"}, app_en, t.e_en);
        check({tag, " wren"}, wdf_wren, t.e_wren);
        check({tag, " wdf_end"}, wdf_end, t.e_wren);
        check({tag, " wr_done"}, wr_done, t.e_done);
        check({tag, " busy"}, busy, t.e_busy);
        check({tag, " app_cmd"}, app_cmd, 3'b000);
        check({tag, " app_addr"}, app_addr, t.e_addr);
        check({tag, " wdf_data"}, wdf_data, t.e_busy ? data_of(t.e_addr) : '0);
        check({tag, " wdf_mask"}, wdf_mask, t.e_busy ? mask_of(t.e_addr) : '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " app_en"}, app_en, 1'b0);
        check({tag, " wren"}, wdf_wren, 1'b0);
        check({tag, " wdf_end"}, wdf_end, 1'b0);
        check({tag, " wr_done"}, wr_done, 1'b0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " ready"}, wr_ready, 1'b1);
        check({tag, " app_cmd"}, app_cmd, 3'b000);
        check({tag, " app_addr"}, app_addr, '0);
        check({tag, " wdf_data"}, wdf_data, '0);
        check({tag, " wdf_mask"}, wdf_mask, '0);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } req_t;

    vec_t vecs[$];
    req_t q[$];

    initial begin
        rst = 1'b1; calib = 1'b0; wr_valid = 1'b0; wr_addr = '0;
        wr_data = '0; wr_mask = '0; app_rdy = 1'b0; wdf_rdy = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single write, then fill to full with both ready low, then drain.
        vecs.push_back(mk(1, 28'h100, 1, 1, 1, 1, 0, 0, 0, 0, 28'h0));
        vecs.push_back(mk(0, 28'h0,   1, 1, 1, 1, 1, 1, 0, 1, 28'h100));
        vecs.push_back(mk(0, 28'h0,   1, 1, 1, 1, 0, 0, 1, 0, 28'h0));
        vecs.push_back(mk(0, 28'h0,   1, 1, 1, 1, 0, 0, 0, 0, 28'h0));
        vecs.push_back(mk(1, 28'h10,  1, 0, 0, 1, 0, 0, 0, 0, 28'h0));
        vecs.push_back(mk(1, 28'h20,  1, 0, 0, 1, 1, 1, 0, 1, 28'h10));
        vecs.push_back(mk(1, 28'h30,  1, 0, 0, 1, 1, 1, 0, 1, 28'h10));
        vecs.push_back(mk(1, 28'h40,  1, 0, 0, 1, 1, 1, 0, 1, 28'h10));
        vecs.push_back(mk(1, 28'h50,  1, 0, 0, 0, 1, 1, 0, 1, 28'h10));
        vecs.push_back(mk(1, 28'h50,  1, 1, 1, 0, 1, 1, 0, 1, 28'h10));
        vecs.push_back(mk(0, 28'h0,   1, 1, 1, 1, 1, 1, 1, 1, 28'h20));
        vecs.push_back(mk(0, 28'h0,   1, 1, 1, 1, 1, 1, 1, 1, 28'h30));
        vecs.push_back(mk(0, 28'h0,   1, 1, 1, 1, 1, 1, 1, 1, 28'h40));
        vecs.push_back(mk(0, 28'h0,   1, 1, 1, 1, 0, 0, 1, 0, 28'h0));
        vecs.push_back(mk(0, 28'h0,   1, 1, 1, 1, 0, 0, 0, 0, 28'h0));
        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Data accepted first, command held off for three cycles.
        apply("split0", mk(1, 28'h200, 1, 0, 1, 1, 0, 0, 0, 0, 28'h0));
        apply("split1", mk(0, 28'h0,   1, 0, 1, 1, 1, 1, 0, 1, 28'h200));
        apply("split2", mk(0, 28'h0,   1, 0, 1, 1, 1, 0, 0, 1, 28'h200));
        apply("split3", mk(0, 28'h0,   1, 0, 1, 1, 1, 0, 0, 1, 28'h200));
        apply("split4", mk(0, 28'h0,   1, 1, 1, 1, 1, 0, 0, 1, 28'h200));
        apply("split5", mk(0, 28'h0,   1, 1, 1, 1, 0, 0, 1, 0, 28'h0));
        apply("split6", mk(0, 28'h0,   1, 1, 1, 1, 0, 0, 0, 0, 28'h0));

        // Command accepted first, data ready held off for five cycles.
        apply("rev0", mk(1, 28'h300, 1, 1, 0, 1, 0, 0, 0, 0, 28'h0));
        apply("rev1", mk(0, 28'h0,   1, 1, 0, 1, 1, 1, 0, 1, 28'h300));
        for (int i = 2; i <= 5; i++) begin
            apply($sformatf("rev%0d", i), mk(0, 28'h0, 1, 1, 0, 1, 0, 1, 0, 1, 28'h300));
        end
        apply("rev6", mk(0, 28'h0, 1, 1, 1, 1, 0, 1, 0, 1, 28'h300));
        apply("rev7", mk(0, 28'h0, 1, 1, 1, 1, 0, 0, 1, 0, 28'h0));
        apply("rev8", mk(0, 28'h0, 1, 1, 1, 1, 0, 0, 0, 0, 28'h0));

        // Requests queue up while calibration is pending, then issue in order.
        apply("cal0", mk(1, 28'h400, 0, 1, 1, 1, 0, 0, 0, 0, 28'h0));
        apply("cal1", mk(1, 28'h410, 0, 1, 1, 1, 0, 0, 0, 1, 28'h400));
        apply("cal2", mk(0, 28'h0,   0, 1, 1, 1, 0, 0, 0, 1, 28'h400));
        apply("cal3", mk(0, 28'h0,   1, 1, 1, 1, 1, 1, 0, 1, 28'h400));
        apply("cal4", mk(0, 28'h0,   1, 1, 1, 1, 1, 1, 1, 1, 28'h410));
        apply("cal5", mk(0, 28'h0,   1, 1, 1, 1, 0, 0, 1, 0, 28'h0));
        apply("cal6", mk(0, 28'h0,   1, 1, 1, 1, 0, 0, 0, 0, 28'h0));

        // Asynchronous reset while only the command half is outstanding.
        apply("rst0", mk(1, 28'h500, 1, 0, 1, 1, 0, 0, 0, 0, 28'h0));
        apply("rst1", mk(0, 28'h0,   1, 0, 1, 1, 1, 1, 0, 1, 28'h500));
        apply("rst2", mk(0, 28'h0,   1, 0, 1, 1, 1, 0, 0, 1, 28'h500));
        #0.5;
        rst = 1'b1;
        #0.2;
        check_reset_outputs("rst_async");
        @(negedge clk);
        rst = 1'b0;
        apply("rst_after0", mk(0, 28'h0, 1, 1, 1, 1, 0, 0, 0, 0, 28'h0));
        apply("rst_after1", mk(0, 28'h0, 1, 1, 1, 1, 0, 0, 0, 0, 28'h0));

        // Randomized traffic against a queue model of the request stream.
        begin
            logic m_cmd, m_data, m_done;
            logic head, e_en, e_wren, e_ready, cmd_hs, data_hs, pop, push;
            req_t r;
            m_cmd = 1'b0; m_data = 1'b0; m_done = 1'b0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(negedge clk);
                wr_valid = ($urandom_range(0, 99) < 55);
                calib    = ($urandom_range(0, 99) < 85);
                app_rdy  = ($urandom_range(0, 99) < 65);
                wdf_rdy  = ($urandom_range(0, 99) < 65);
                wr_addr  = AW'($urandom);
                wr_data  = {$urandom, $urandom, $urandom, $urandom};
                wr_mask  = MW'($urandom);
                #1;
                head    = (q.size() != 0);
                e_ready = (q.size() < DEPTH);
                e_en    = head & calib & ~m_cmd;
                e_wren  = head & calib & ~m_data;
                check("rnd ready", wr_ready, e_ready);
                check("rnd busy", busy, head);
                check("rnd app_en", app_en, e_en);
                check("rnd wren", wdf_wren, e_wren);
                check("rnd wdf_end", wdf_end, e_wren);
                check("rnd wr_done", wr_done, m_done);
                check("rnd app_cmd", app_cmd, 3'b000);
                check("rnd app_addr", app_addr, head ? q[0].addr : '0);
                check("rnd wdf_data", wdf_data, head ? q[0].data : '0);
                check("rnd wdf_mask", wdf_mask, head ? q[0].mask : '0);

                cmd_hs  = e_en & app_rdy;
                data_hs = e_wren & wdf_rdy;
                pop     = head & (m_cmd | cmd_hs) & (m_data | data_hs);
                push    = wr_valid & e_ready;
                if (pop) begin
                    void'(q.pop_front());
                    m_cmd  = 1'b0;
                    m_data = 1'b0;
                end else begin
                    m_cmd  = m_cmd | cmd_hs;
                    m_data = m_data | data_hs;
                end
                if (push) begin
                    r.addr = wr_addr; r.data = wr_data; r.mask = wr_mask;
                    q.push_back(r);
                end
                m_done = pop;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
